riscv_dmem: RTL
===============

RISCV_DMEM -- requirements
Module: riscv_dmem

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the data array.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 1, meaning the number of wait states between request accept and array access (0..15).
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rstn  input  1  reset, synchronous and active-low.
REQ-005 i_dmem_req  input  1  request valid from the datapath load/store path.
REQ-006 i_dmem_we  input  1  1 = store, 0 = load; sampled with i_dmem_req.
REQ-007 i_dmem_addr  input  XLEN  byte address (datapath ALU result).
REQ-008 i_dmem_wr_data  input  XLEN  store data (datapath rs2), right-aligned.
REQ-009 i_dmem_funct3  input  3  access size and sign: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-010 o_dmem_ready  output  1  responder can accept a request this cycle.
REQ-011 o_dmem_rsp_valid  output  1  one-cycle pulse: response/completion.
REQ-012 o_dmem_rd_data  output  XLEN  extended load data; valid only with o_dmem_rsp_valid.
REQ-013 o_dmem_err  output  1  access fault; valid only with o_dmem_rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; o_dmem_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where o_dmem_ready=1 and i_dmem_req=1; addr, we, wr_data, funct3 SHALL be captured at that edge.
REQ-016 On accept: fault -> RESP; else WAIT_CYCLES=0 -> RESP; else -> WAIT with wait counter loaded to WAIT_CYCLES-1.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-018 The array access (read sample or write commit) SHALL occur on the edge entering RESP; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-019 RESP SHALL assert o_dmem_rsp_valid for exactly one cycle and return to IDLE unconditionally (no backpressure); back-to-back accept is possible one cycle after RESP.
REQ-020 Fault SHALL be: halfword with addr[0]=1, word with addr[1:0]!=0, addr[XLEN-1:2] >= DEPTH_WORDS, or funct3 not listed in REQ-009 for the given direction (011,110,111; store 1xx).
REQ-021 On fault: o_dmem_err=1, o_dmem_rd_data=0, array unmodified.
REQ-022 Store SHALL write only byte lanes selected by size and addr[1:0]; SB lane = addr[1:0], SH lanes = addr[1]*2 +{0,1}; other lanes retain contents.
REQ-023 Load SHALL select bytes per addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-024 Store response SHALL drive o_dmem_rd_data=0, o_dmem_err=0.
REQ-025 i_dmem_req while o_dmem_ready=0 SHALL be ignored (not queued); the requester holds it until accepted.
REQ-026 o_dmem_rd_data and o_dmem_err SHALL be 0 whenever o_dmem_rsp_valid=0.

Reset
REQ-027 While i_rstn=0 at an edge: state=IDLE, counter=0, o_dmem_rsp_valid=0, o_dmem_rd_data=0, o_dmem_err=0; o_dmem_ready=1 after the first edge with i_rstn=1 observed... state IDLE.
REQ-028 Reset SHALL take priority over all transitions; reset mid-WAIT SHALL abort the access with no write and no response.
REQ-029 Array contents SHALL NOT be reset.

Structure
REQ-030 funct3 encodings and FSM state encodings SHALL live in the shared configs include alongside XLEN.
REQ-031 Byte-lane steering and load extension SHALL be one combinational sub-module riscv_dmem_fmt; FSM, counter, array in riscv_dmem.

Verification
REQ-032 WAIT_CYCLES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 cycles after each accept, rd_data=0xDEADBEEF, err=0.
REQ-033 SB 0x13 data 0x000000A5 onto 0x11223344 word at 0x10; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LW 0x10 -> 0xA5223344.
REQ-034 SH 0x12 data 0x8001; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
REQ-035 LW 0x11, SH 0x13, LW 0x1000 (DEPTH_WORDS=1024) -> err=1, rd_data=0, following LW 0x10 shows word unchanged.
REQ-036 SW 0x20 data 0x12345678, i_rstn=0 for one edge while in WAIT -> no rsp_valid; subsequent LW 0x20 returns prior contents.
REQ-037 WAIT_CYCLES=0 and WAIT_CYCLES=3 with req held high continuously -> accepts every 2 and 5 cycles, ready low in between.

Source files
------------

// File: rtl/riscv_dmem_pkg.sv
// Shared configuration for the data-memory responder: XLEN, funct3 encodings and FSM states.
package riscv_dmem_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/riscv_dmem_if.sv
// Datapath load/store request/response bus between the core and the data memory.
interface riscv_dmem_if;
  import riscv_dmem_pkg::*;

  logic            i_dmem_req;
  logic            i_dmem_we;
  logic [XLEN-1:0] i_dmem_addr;
  logic [XLEN-1:0] i_dmem_wr_data;
  logic [2:0]      i_dmem_funct3;
  logic            o_dmem_ready;
  logic            o_dmem_rsp_valid;
  logic [XLEN-1:0] o_dmem_rd_data;
  logic            o_dmem_err;

  modport master (
    output i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wr_data, i_dmem_funct3,
    input  o_dmem_ready, o_dmem_rsp_valid, o_dmem_rd_data, o_dmem_err
  );

  modport slave (
    input  i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wr_data, i_dmem_funct3,
    output o_dmem_ready, o_dmem_rsp_valid, o_dmem_rd_data, o_dmem_err
  );
endinterface

// File: rtl/riscv_dmem_fmt.sv
// Byte-lane steering for stores, byte selection and extension for loads, and
// size/alignment/encoding fault detection. Purely combinational.
module riscv_dmem_fmt
  import riscv_dmem_pkg::*;
(
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0] rd_word_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wr_word_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            fmt_err_o
);

  logic [XLEN-1:0] shifted;

  // Addressed byte/halfword lands in the low bits; misaligned words fault, so no shift matters there.
  assign shifted = rd_word_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o      = 4'b0000;
    wr_word_o = wr_data_i;
    ld_data_o = '0;
    fmt_err_o = 1'b0;
    unique case (funct3_i)
      F3_B: begin
        be_o      = 4'b0001 << addr_lo_i;
        wr_word_o = {4{wr_data_i[7:0]}};
        ld_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wr_word_o = {2{wr_data_i[15:0]}};
        ld_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        fmt_err_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o      = 4'b1111;
        ld_data_o = shifted;
        fmt_err_o = |addr_lo_i;
      end
      F3_BU: begin
        ld_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
        fmt_err_o = we_i;
      end
      F3_HU: begin
        ld_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
        fmt_err_o = we_i | addr_lo_i[0];
      end
      default: fmt_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_dmem.sv
// Data memory responder: IDLE/WAIT/RESP handshake FSM, wait-state counter and
// word array; the access happens on the edge that enters RESP.
module riscv_dmem
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  riscv_dmem_if.slave  bus
);

  localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [XLEN-3:0]  DEPTH_LIM = (XLEN-2)'(DEPTH_WORDS);
  localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rd_data_q;
  logic            err_q;

  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            idle, accept, go_resp_d, fault_d, do_write;
  logic            cur_we;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [2:0]      cur_f3;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] rd_word, wr_word, ld_data, rd_data_d;
  logic [3:0]      be;
  logic            fmt_err;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & bus.i_dmem_req;

  // In IDLE the live request is the operand so a zero-wait access can use it on the accept edge.
  assign cur_we    = idle ? bus.i_dmem_we      : we_q;
  assign cur_addr  = idle ? bus.i_dmem_addr    : addr_q;
  assign cur_wdata = idle ? bus.i_dmem_wr_data : wdata_q;
  assign cur_f3    = idle ? bus.i_dmem_funct3  : f3_q;

  assign word_idx = cur_addr[AW+1:2];
  assign rd_word  = mem_q[word_idx];

  riscv_dmem_fmt u_fmt (
    .we_i      (cur_we),
    .funct3_i  (cur_f3),
    .addr_lo_i (cur_addr[1:0]),
    .wr_data_i (cur_wdata),
    .rd_word_i (rd_word),
    .be_o      (be),
    .wr_word_o (wr_word),
    .ld_data_o (ld_data),
    .fmt_err_o (fmt_err)
  );

  assign fault_d   = fmt_err | (cur_addr[XLEN-1:2] >= DEPTH_LIM);
  assign go_resp_d = (accept & (fault_d | ZERO_WAIT)) |
                     ((state_q == ST_WAIT) & (cnt_q == 4'd0));
  assign do_write  = i_rstn & go_resp_d & cur_we & ~fault_d;
  assign rd_data_d = (fault_d | cur_we) ? '0 : ld_data;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      if (go_resp_d) begin
        rsp_valid_q <= 1'b1;
        rd_data_q   <= rd_data_d;
        err_q       <= fault_d;
      end
      unique case (state_q)
        ST_IDLE: if (accept) begin
          if (go_resp_d) state_q <= ST_RESP;
          else begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q    <= bus.i_dmem_we;
      addr_q  <= bus.i_dmem_addr;
      wdata_q <= bus.i_dmem_wr_data;
      f3_q    <= bus.i_dmem_funct3;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.o_dmem_ready     = idle;
  assign bus.o_dmem_rsp_valid = rsp_valid_q;
  assign bus.o_dmem_rd_data   = rd_data_q;
  assign bus.o_dmem_err       = err_q;

endmodule
